uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter: the stage directly downstream of the memory-to-serial send controller. It accepts characters on a single-cycle write strobe into a small synchronous FIFO, reports back-pressure on `tx_full`, and serialises each byte onto the `tx` line at a fixed baud divisor. Its outputs drive the board's USB-UART pin.

---
 rtl/uart_pkg.sv | 12 +
 rtl/tx_fifo.sv | 39 +++
 rtl/uart_tx_buffered.sv | 91 +++++++++
 tb/tb_uart_tx_buffered.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the UART transmit path
package uart_pkg;
    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Start = 2'd1,
        Data  = 2'd2,
        Stop  = 2'd3
    } tx_state_t;
    localparam int DefaultBaudDivisor = 10417;
    localparam int DataBits = 8;
    localparam logic IdleLevel = 1'b1;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous first-word-fall-through FIFO with registered occupancy count
module tx_fifo #(
    parameter int Width     = 8,
    parameter int DepthBits = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic [Width-1:0] wr_data,
    input  logic             rd,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam logic [DepthBits:0] Depth = {1'b1, {DepthBits{1'b0}}};
    logic [Width-1:0] mem [1 << DepthBits];
    logic [DepthBits-1:0] wr_ptr, rd_ptr;
    logic [DepthBits:0] count;
    logic do_wr, do_rd;
    assign full    = count == Depth;
    assign empty   = count == '0;
    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{DepthBits{1'b0}}, do_wr} - {{DepthBits{1'b0}}, do_rd};
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter with a fixed baud divisor
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BaudDivisor   = DefaultBaudDivisor,
    parameter int FifoDepthBits = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_to_uart,
    input  logic [7:0] data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       busy,
    output logic       tx
);
    localparam int CountBits = $clog2(BaudDivisor);
    localparam int IdxBits = $clog2(DataBits);
    localparam logic [CountBits-1:0] Reload = CountBits'(BaudDivisor - 1);
    localparam logic [IdxBits-1:0] LastBit = IdxBits'(DataBits - 1);
    tx_state_t state, state_next;
    logic [CountBits-1:0] count, count_next;
    logic [DataBits-1:0] shift, shift_next, head;
    logic [IdxBits-1:0] bit_idx, bit_idx_next;
    logic tx_next, pop;
    tx_fifo #(
        .Width    (DataBits),
        .DepthBits(FifoDepthBits)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr     (write_to_uart),
        .wr_data(data),
        .rd     (pop),
        .rd_data(head),
        .full   (tx_full),
        .empty  (tx_empty)
    );
    assign busy = state != Idle;
    always_comb begin
        state_next   = state;
        count_next   = count - 1'b1;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        pop          = 1'b0;
        unique case (state)
            Idle: begin
                count_next = count;
                if (!tx_empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    count_next = Reload;
                    state_next = Start;
                end
            end
            Start: if (count == '0) begin
                count_next   = Reload;
                bit_idx_next = '0;
                state_next   = Data;
            end
            Data: if (count == '0) begin
                shift_next   = shift >> 1;
                bit_idx_next = bit_idx + 1'b1;
                count_next   = Reload;
                state_next   = bit_idx == LastBit ? Stop : Data;
            end
            Stop: if (count == '0) begin
                count_next = '0;
                state_next = Idle;
            end
            default: state_next = Idle;
        endcase
        // tx is registered, so it is driven from the state being entered
        tx_next = state_next == Start ? 1'b0 : state_next == Data ? shift_next[0] : IdleLevel;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= Idle;
            count   <= '0;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= IdleLevel;
        end else begin
            state   <= state_next;
            count   <= count_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of the buffered UART transmitter at BaudDivisor=4
module tb_uart_tx_buffered;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic write_to_uart = 1'b0;
    logic [7:0] data = 8'h00;
    logic tx_full, tx_empty, busy, tx;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base;
    int rx_phase = -1;
    int rx_start = 0;
    logic [9:0] rx_sh = '0;
    logic [9:0] rx_frames[$];
    int rx_starts[$];
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[5];

    uart_tx_buffered #(
        .BaudDivisor  (4),
        .FifoDepthBits(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_to_uart(write_to_uart),
        .data         (data),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .busy         (busy),
        .tx           (tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // line receiver: frames are {stop, data, start}, sampled one cycle into each bit
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (reset) rx_phase = -1;
            else if (rx_phase < 0) begin
                if (tx === 1'b0) begin
                    rx_phase = 0;
                    rx_start = cyc;
                end
            end else rx_phase++;
            if (rx_phase >= 0 && rx_phase % 4 == 1) rx_sh[rx_phase / 4] = tx;
            if (rx_phase == 39) begin
                rx_frames.push_back(rx_sh);
                rx_starts.push_back(rx_start);
                rx_phase = -1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input int i, input logic [9:0] exp, input string nm);
        chk(nm, i < rx_frames.size() ? 32'(rx_frames[i]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic wait_frames(input int n, input string nm);
        int w = 0;
        while (rx_frames.size() < n && w < 1000) begin
            @(negedge clock);
            w++;
        end
        chk(nm, rx_frames.size(), n);
    endtask

    task automatic settle();
        repeat (5) @(negedge clock);
    endtask

    initial begin
        vecs[0] = '{8'h41, 10'h282};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h80, 10'h300};
        vecs[4] = '{8'h01, 10'h202};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset empty", tx_empty, 1);
        chk("reset full", tx_full, 0);
        repeat (20) @(negedge clock);
        chk("held tx", tx, 1);
        chk("held busy", busy, 0);
        chk("held empty", tx_empty, 1);
        chk("held full", tx_full, 0);

        foreach (vecs[i]) begin
            base = rx_frames.size();
            data = vecs[i].data;
            write_to_uart = 1'b1;
            @(negedge clock);
            write_to_uart = 1'b0;
            chk("edge N empty", tx_empty, 0);
            chk("edge N tx", tx, 1);
            chk("edge N busy", busy, 0);
            @(negedge clock);
            chk("edge N+1 tx", tx, 0);
            chk("edge N+1 busy", busy, 1);
            chk("edge N+1 empty", tx_empty, 1);
            repeat (39) @(negedge clock);
            chk("last busy cycle", busy, 1);
            chk("stop bit", tx, 1);
            @(negedge clock);
            chk("busy end", busy, 0);
            chk("idle tx", tx, 1);
            wait_frames(base + 1, "single count");
            chk_frame(base, vecs[i].frame, "single frame");
        end

        settle();
        base = rx_frames.size();
        data = 8'h55;
        write_to_uart = 1'b1;
        @(negedge clock);
        data = 8'hAA;
        @(negedge clock);
        data = 8'h0D;
        @(negedge clock);
        data = 8'h0A;
        @(negedge clock);
        write_to_uart = 1'b0;
        wait_frames(base + 4, "b2b count");
        chk_frame(base, 10'h2AA, "b2b frame0");
        chk_frame(base + 1, 10'h354, "b2b frame1");
        chk_frame(base + 2, 10'h21A, "b2b frame2");
        chk_frame(base + 3, 10'h214, "b2b frame3");
        for (int k = 1; k < 4; k++) chk("b2b gap", rx_starts[base + k] - rx_starts[base + k - 1], 41);
        chk("b2b span", rx_starts[base + 3] + 40 - rx_starts[base], 163);

        settle();
        base = rx_frames.size();
        data = 8'h30;
        write_to_uart = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("ovf full", tx_full, k >= 5);
            chk("ovf busy", busy, k >= 2);
            chk("ovf empty", tx_empty, 0);
            if (k < 6) data = 8'(8'h30 + k);
            else write_to_uart = 1'b0;
        end
        wait_frames(base + 5, "ovf count");
        chk_frame(base, 10'h260, "ovf 0x30");
        chk_frame(base + 1, 10'h262, "ovf 0x31");
        chk_frame(base + 2, 10'h264, "ovf 0x32");
        chk_frame(base + 3, 10'h266, "ovf 0x33");
        chk_frame(base + 4, 10'h268, "ovf 0x34");
        repeat (100) @(negedge clock);
        chk("ovf 0x35 dropped", rx_frames.size(), base + 5);

        settle();
        base = rx_frames.size();
        data = 8'h41;
        write_to_uart = 1'b1;
        @(negedge clock);
        data = 8'h42;
        @(negedge clock);
        data = 8'h43;
        @(negedge clock);
        write_to_uart = 1'b0;
        chk("mid queued", tx_empty, 0);
        repeat (16) @(negedge clock);
        chk("mid bit3", tx, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid reset tx", tx, 1);
        chk("mid reset empty", tx_empty, 1);
        chk("mid reset busy", busy, 0);
        chk("mid reset full", tx_full, 0);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        chk("mid no frames", rx_frames.size(), base);
        chk("mid tx idle", tx, 1);
        chk("mid still empty", tx_empty, 1);

        settle();
        base = rx_frames.size();
        data = 8'h11;
        write_to_uart = 1'b1;
        @(negedge clock);
        data = 8'h21;
        @(negedge clock);
        data = 8'h22;
        @(negedge clock);
        data = 8'h23;
        @(negedge clock);
        data = 8'h24;
        @(negedge clock);
        write_to_uart = 1'b0;
        chk("sim full", tx_full, 1);
        for (int w = 0; w < 100 && busy; w++) @(negedge clock);
        chk("sim idle", busy, 0);
        chk("sim idle full", tx_full, 1);
        data = 8'h99;
        write_to_uart = 1'b1;
        @(negedge clock);
        write_to_uart = 1'b0;
        chk("sim full after E", tx_full, 0);
        chk("sim busy after E", busy, 1);
        chk("sim empty after E", tx_empty, 0);
        data = 8'h77;
        write_to_uart = 1'b1;
        @(negedge clock);
        write_to_uart = 1'b0;
        chk("sim refill full", tx_full, 1);
        wait_frames(base + 6, "sim count");
        chk_frame(base, 10'h222, "sim 0x11");
        chk_frame(base + 1, 10'h242, "sim 0x21");
        chk_frame(base + 2, 10'h244, "sim 0x22");
        chk_frame(base + 3, 10'h246, "sim 0x23");
        chk_frame(base + 4, 10'h248, "sim 0x24");
        chk_frame(base + 5, 10'h2EE, "sim 0x77");
        repeat (60) @(negedge clock);
        chk("sim 0x99 dropped", rx_frames.size(), base + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
